// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for the pipelined adder: upstream beat, downstream beat and both handshakes.
// The adder takes the slave view; whoever feeds and drains it takes the master view.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-wide ripple slice per stage,
// carry registered between stages, valid/ready on both sides with full-rate throughput.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  pipelined_adder_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + 1, so inversion and the forced carry happen before stage 0.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;
    localparam int HI   = WIDTH - DONE;

    logic             valid_q;
    logic             valid_in;
    logic             load;
    logic             carry_q;
    logic             carry_in;
    logic             a_msb_q;
    logic             a_msb_in;
    logic             b_msb_q;
    logic             b_msb_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [DONE-1:0]  res_q;
    logic [DONE-1:0]  res_in;

    if (k == 0) begin : g_src
      assign valid_in = bus.in_valid;
      assign a_chunk  = bus.a[CHUNK-1:0];
      assign b_chunk  = b_eff[CHUNK-1:0];
      assign carry_in = c0;
      assign a_msb_in = bus.a[WIDTH-1];
      assign b_msb_in = b_eff[WIDTH-1];
      assign res_in   = chunk_sum[CHUNK-1:0];
    end else begin : g_src
      assign valid_in = g_stage[k-1].valid_q;
      assign a_chunk  = g_stage[k-1].g_hi.a_q[CHUNK-1:0];
      assign b_chunk  = g_stage[k-1].g_hi.b_q[CHUNK-1:0];
      assign carry_in = g_stage[k-1].carry_q;
      assign a_msb_in = g_stage[k-1].a_msb_q;
      assign b_msb_in = g_stage[k-1].b_msb_q;
      assign res_in   = {chunk_sum[CHUNK-1:0], g_stage[k-1].res_q};
    end

    // A stage may take new data when empty or when its occupant moves on this same edge.
    if (k == LAST) begin : g_load
      assign load = !valid_q || bus.out_ready;
    end else begin : g_load
      assign load = !valid_q || g_stage[k+1].load;
    end

    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        res_q   <= '0;
        carry_q <= 1'b0;
        a_msb_q <= 1'b0;
        b_msb_q <= 1'b0;
      end else if (load) begin
        valid_q <= valid_in;
        if (valid_in) begin
          res_q   <= res_in;
          carry_q <= chunk_sum[CHUNK];
          a_msb_q <= a_msb_in;
          b_msb_q <= b_msb_in;
        end
      end
    end

    // Operand bits not yet summed ride along until their own stage consumes them.
    if (HI > 0) begin : g_hi
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;
      logic [HI-1:0] a_in;
      logic [HI-1:0] b_in;

      if (k == 0) begin : g_src
        assign a_in = bus.a[WIDTH-1:CHUNK];
        assign b_in = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src
        assign a_in = g_stage[k-1].g_hi.a_q[HI+CHUNK-1:CHUNK];
        assign b_in = g_stage[k-1].g_hi.b_q[HI+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load && valid_in) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end
  end

  assign bus.in_ready  = g_stage[0].load;
  assign bus.out_valid = g_stage[LAST].valid_q;
  assign bus.sum       = g_stage[LAST].res_q;
  assign bus.c_out     = g_stage[LAST].carry_q;

  // Signed overflow: operands agree in sign but the result does not.
  assign bus.overflow  = (g_stage[LAST].a_msb_q == g_stage[LAST].b_msb_q) &&
                         (g_stage[LAST].res_q[WIDTH-1] != g_stage[LAST].a_msb_q);

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.sum) && $stable(bus.c_out) && $stable(bus.overflow)));

endmodule
